// File: rtl/regfile_wb_seq_pkg.sv
// regfile_wb_seq_pkg: shared types and constants for the writeback sequencer.
package regfile_wb_seq_pkg;
    typedef enum logic [2:0] {
        WB_WORD = 3'd0,
        WB_LB   = 3'd1,
        WB_LH   = 3'd2,
        WB_LBU  = 3'd3,
        WB_LHU  = 3'd4
    } wb_type_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_t;
    localparam int HALF_W = 16;
endpackage

// File: rtl/regfile_wb_seq_load_fmt.sv
// wb_load_fmt: selects and extends the load byte/half; unknown codes pass the word through.
module wb_load_fmt
    import regfile_wb_seq_pkg::*;
(
    input  logic [31:0] result_i,
    input  logic [2:0]  wb_type_i,
    input  logic [1:0]  byte_off_i,
    output logic [31:0] fmt_o
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        is_b, is_h, sgn;
    assign b    = result_i[{byte_off_i, 3'b000} +: 8];
    // byte_off_i[0] is ignored for halves: misaligned halves trap upstream
    assign h    = result_i[{byte_off_i[1], 4'b0000} +: 16];
    assign is_b = (wb_type_i == WB_LB) | (wb_type_i == WB_LBU);
    assign is_h = (wb_type_i == WB_LH) | (wb_type_i == WB_LHU);
    assign sgn  = (wb_type_i == WB_LB) | (wb_type_i == WB_LH);
    assign fmt_o = is_b ? {{24{sgn & b[7]}}, b}
                 : is_h ? {{16{sgn & h[15]}}, h}
                 : result_i;
endmodule

// File: rtl/regfile_wb_seq.sv
// regfile_wb_seq: splits each 32-bit writeback into low-then-high half-writes
// and exports the in-flight destination for decode hazard stalls.
module regfile_wb_seq
    import regfile_wb_seq_pkg::*;
#(
    parameter bit SKIP_X0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [4:0]  rd_i,
    input  logic [31:0] result_i,
    input  logic [2:0]  wb_type_i,
    input  logic [1:0]  byte_off_i,
    output logic        write_o,
    output logic [4:0]  rd_o,
    output logic        rd_h_sel_o,
    output logic [15:0] write_data_o,
    output logic        pend_valid_o,
    output logic [4:0]  pend_rd_o
);
    wb_state_t   state_q, state_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic [31:0] hold_data_q, hold_data_d, fmt;
    logic        accept, skip;

    wb_load_fmt u_fmt (
        .result_i   (result_i),
        .wb_type_i  (wb_type_i),
        .byte_off_i (byte_off_i),
        .fmt_o      (fmt)
    );

    assign ready_o = ~rst & (state_q != WR_LO);
    assign accept  = valid_i & ready_o;
    assign skip    = SKIP_X0 && (rd_i == 5'd0);

    always_comb begin
        state_d     = (state_q == WR_LO) ? WR_HI : IDLE;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        if (accept) begin
            state_d = skip ? IDLE : WR_LO;
            if (!skip) begin
                hold_rd_d   = rd_i;
                hold_data_d = fmt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Write strobe stays low for x0 so the SKIP_X0=0 slots are harmless
    assign pend_valid_o = state_q != IDLE;
    assign pend_rd_o    = pend_valid_o ? hold_rd_q : '0;
    assign rd_o         = pend_rd_o;
    assign write_o      = pend_valid_o & (hold_rd_q != 5'd0);
    assign rd_h_sel_o   = state_q == WR_HI;
    assign write_data_o = rd_h_sel_o   ? hold_data_q[2*HALF_W-1:HALF_W]
                        : pend_valid_o ? hold_data_q[HALF_W-1:0]
                        : '0;
endmodule

// File: tb/tb_regfile_wb_seq.sv
// tb_regfile_wb_seq: randomized and directed checks of the writeback sequencer
// against a behavioural formatting model and expected per-cycle output vectors.
module tb_regfile_wb_seq;
    logic        clk, rst, valid_i;
    logic [4:0]  rd_i;
    logic [31:0] result_i;
    logic [2:0]  wb_type_i;
    logic [1:0]  byte_off_i;
    logic        write_o, ready_o, rd_h_sel_o, pend_valid_o;
    logic [4:0]  rd_o, pend_rd_o;
    logic [15:0] write_data_o;
    logic        write0, ready0, hsel0, pv0;
    logic [4:0]  rd0, prd0;
    logic [15:0] wd0;
    logic [29:0] obs, obs0, exp_v;
    int          errors = 0, checks = 0;

    regfile_wb_seq #(.SKIP_X0(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .rd_i(rd_i),
        .result_i(result_i), .wb_type_i(wb_type_i), .byte_off_i(byte_off_i),
        .write_o(write_o), .rd_o(rd_o), .rd_h_sel_o(rd_h_sel_o),
        .write_data_o(write_data_o), .pend_valid_o(pend_valid_o), .pend_rd_o(pend_rd_o)
    );
    regfile_wb_seq #(.SKIP_X0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready0), .rd_i(rd_i),
        .result_i(result_i), .wb_type_i(wb_type_i), .byte_off_i(byte_off_i),
        .write_o(write0), .rd_o(rd0), .rd_h_sel_o(hsel0),
        .write_data_o(wd0), .pend_valid_o(pv0), .pend_rd_o(prd0)
    );

    // {write, rd, h_sel, data, ready, pend_valid, pend_rd}
    assign obs  = {write_o, rd_o, rd_h_sel_o, write_data_o, ready_o, pend_valid_o, pend_rd_o};
    assign obs0 = {write0, rd0, hsel0, wd0, ready0, pv0, prd0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model(logic [31:0] r, int t, int off);
        int b, h;
        b = int'((r >> (8 * off)) & 32'hFF);
        h = int'((r >> (16 * (off / 2))) & 32'hFFFF);
        case (t)
            1: return (b >= 128) ? 32'(b - 256) : 32'(b);
            3: return 32'(b);
            2: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            4: return 32'(h);
            default: return r;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; rd_i = '0; result_i = '0; wb_type_i = '0; byte_off_i = '0;
        #12;
        checks++;
        if (obs !== 30'd0) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, 30'd0); end
        @(posedge clk); #1 rst = 1'b0; #1;
        exp_v = {1'b0, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 5'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_v); end
        checks++;
        if (obs0 !== exp_v) begin errors++; $display("FAIL reset_release0: got %h expected %h", obs0, exp_v); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_fmt();
        logic [31:0] res_t [6] = '{32'hDEADBEEF, 32'h0080FF00, 32'h0080FF00, 32'h80011234, 32'h80011234, 32'h12345678};
        int          typ_t [6] = '{0, 1, 3, 2, 4, 6};
        int          off_t [6] = '{0, 2, 2, 2, 2, 1};
        logic [31:0] e;
        logic [4:0]  rd;
        int          t, off;
        for (int i = 0; i < 30; i++) begin
            if (i < 6) begin
                result_i = res_t[i]; t = typ_t[i]; off = off_t[i]; rd = (i == 0) ? 5'd5 : 5'(i + 8);
            end else begin
                result_i = $urandom; t = $urandom_range(0, 7); off = $urandom_range(0, 3); rd = 5'($urandom_range(1, 31));
            end
            e = model(result_i, t, off);
            rd_i = rd; wb_type_i = 3'(t); byte_off_i = 2'(off); valid_i = 1'b1;
            checks++;
            if (ready_o !== 1'b1) begin errors++; $display("FAIL fmt_ready[%0d]: got %b expected 1", i, ready_o); end
            @(posedge clk); #1 valid_i = 1'b0;
            exp_v = {1'b1, rd, 1'b0, e[15:0], 1'b0, 1'b1, rd};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fmt_lo[%0d] type=%0d off=%0d res=%h: got %h expected %h", i, t, off, result_i, obs, exp_v); end
            @(posedge clk); #1;
            exp_v = {1'b1, rd, 1'b1, e[31:16], 1'b1, 1'b1, rd};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fmt_hi[%0d] type=%0d off=%0d res=%h: got %h expected %h", i, t, off, result_i, obs, exp_v); end
            @(posedge clk); #1;
            exp_v = {1'b0, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 5'd0};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fmt_idle[%0d]: got %h expected %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [3];
        logic [4:0]  rd;
        for (int i = 0; i < 3; i++) d[i] = $urandom;
        wb_type_i = 3'd0; byte_off_i = 2'd0;
        rd_i = 5'd1; result_i = d[0]; valid_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rd = 5'(i + 1);
            exp_v = {1'b1, rd, 1'b0, d[i][15:0], 1'b0, 1'b1, rd};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL b2b_lo[%0d]: got %h expected %h", i, obs, exp_v); end
            if (i < 2) begin rd_i = 5'(i + 2); result_i = d[i + 1]; end
            else valid_i = 1'b0;
            @(posedge clk); #1;
            exp_v = {1'b1, rd, 1'b1, d[i][31:16], 1'b1, 1'b1, rd};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL b2b_hi[%0d]: got %h expected %h", i, obs, exp_v); end
            @(posedge clk); #1;
        end
        checks++;
        if (pend_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end: got pend_valid=%b expected 0", pend_valid_o); end
    endtask

    task automatic test_x0();
        logic [31:0] r;
        r = $urandom;
        rd_i = 5'd0; result_i = r; wb_type_i = 3'd0; byte_off_i = 2'd0; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        exp_v = {1'b0, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 5'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL x0_skip: got %h expected %h", obs, exp_v); end
        exp_v = {1'b0, 5'd0, 1'b0, r[15:0], 1'b0, 1'b1, 5'd0};
        checks++;
        if (obs0 !== exp_v) begin errors++; $display("FAIL x0_noskip_lo: got %h expected %h", obs0, exp_v); end
        @(posedge clk); #1;
        exp_v = {1'b0, 5'd0, 1'b1, r[31:16], 1'b1, 1'b1, 5'd0};
        checks++;
        if (obs0 !== exp_v) begin errors++; $display("FAIL x0_noskip_hi: got %h expected %h", obs0, exp_v); end
        @(posedge clk); #1;
        checks++;
        if (pv0 !== 1'b0) begin errors++; $display("FAIL x0_noskip_idle: got pend_valid=%b expected 0", pv0); end
    endtask

    task automatic test_async_reset();
        rd_i = 5'd7; result_i = $urandom; wb_type_i = 3'd0; byte_off_i = 2'd0; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        checks++;
        if ({write_o, pend_valid_o, pend_rd_o} !== {2'b11, 5'd7}) begin
            errors++; $display("FAIL arst_pre: got %b expected %b", {write_o, pend_valid_o, pend_rd_o}, {2'b11, 5'd7});
        end
        #2 rst = 1'b1; #1;
        checks++;
        if (obs !== 30'd0) begin errors++; $display("FAIL arst_immediate: got %h expected %h", obs, 30'd0); end
        @(posedge clk); #1 rst = 1'b0; #1;
        exp_v = {1'b0, 5'd0, 1'b0, 16'd0, 1'b1, 1'b0, 5'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL arst_release: got %h expected %h", obs, exp_v); end
        @(posedge clk); #1;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL arst_no_stale: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_load_fmt();
        test_back_to_back();
        test_x0();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_seq.md
Name: regfile_wb_seq

Overview:
- Writeback sequencer directly upstream of the split 16-bit register file (two 16-bit banks, single half-write port).
- Accepts one 32-bit writeback result per valid/ready handshake and formats load data (byte/half, signed/unsigned).
- Issues two half-writes on consecutive cycles: low bank, then high bank.
- Exports pending-destination info so decode stalls on reads of a half-written register.

Parameters:
- SKIP_X0, 1: when 1, results with rd=0 are consumed in the accept cycle with no write cycles; when 0 they occupy both write cycles with write_o held low.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  upstream result valid
- ready_o  out  1  sequencer can accept a result this cycle
- rd_i  in  5  destination register
- result_i  in  32  raw result (ALU value or aligned load word)
- wb_type_i  in  3  wb_type_t: WB_WORD, WB_LB, WB_LH, WB_LBU, WB_LHU
- byte_off_i  in  2  load address bits [1:0]
- write_o  out  1  regfile write strobe
- rd_o  out  5  regfile destination
- rd_h_sel_o  out  1  0 = low bank, 1 = high bank
- write_data_o  out  16  half being written
- pend_valid_o  out  1  a write sequence is in flight
- pend_rd_o  out  5  destination of the in-flight sequence

Behaviour:
- Reset: asynchronous, active-high; reset is fixed as asynchronous and active-high. While rst is high and on release:
  - state = IDLE; hold_rd = 0, hold_data = 0.
  - write_o = 0, rd_o = 0, rd_h_sel_o = 0, write_data_o = 0, pend_valid_o = 0, pend_rd_o = 0.
  - ready_o = 0 while rst is high, 1 in IDLE afterwards.
- Formatting is combinational at accept time; the 32-bit formatted value is latched.
  - WB_WORD: result_i unchanged.
  - WB_LB / WB_LBU: byte result_i[8*byte_off_i +: 8], sign- or zero-extended to 32.
  - WB_LH / WB_LHU: half result_i[16*byte_off_i[1] +: 16], extended to 32; byte_off_i[0] is ignored because misalignment traps upstream.
  - Undefined wb_type_i codes (5–7) are treated as WB_WORD.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE: ready_o = 1. On accept (valid_i & ready_o):
    - If SKIP_X0 = 1 and rd_i = 0: stay in IDLE, no writes.
    - Otherwise latch rd_i and the formatted value, go to WR_LO.
  - WR_LO: write_o = 1 (0 if rd = 0, the SKIP_X0 = 0 case); rd_h_sel_o = 0; write_data_o = hold_data[15:0]; ready_o = 0; next state WR_HI.
  - WR_HI: write_o as in WR_LO; rd_h_sel_o = 1; write_data_o = hold_data[31:16]; ready_o = 1.
    - On accept: load the new result and go to WR_LO (back-to-back, no bubble).
    - An accepted rd=0 result with SKIP_X0 = 1 goes to IDLE.
    - No accept: go to IDLE.
- Outputs write_o, rd_o, rd_h_sel_o and write_data_o are decoded from registered state and hold regs only; there is no input-to-write combinational path.
- ready_o is a function of state only, with no dependence on valid_i.
- Latency: accept on edge T; low half lands in the regfile at edge T+1, high half at edge T+2. Throughput is one result per 2 cycles.
- Hazard outputs:
  - pend_valid_o = 1 in WR_LO and WR_HI, 0 in IDLE.
  - pend_rd_o = hold_rd, and reads 0 when idle.
  - Decode stalls while pend_valid_o & (rs == pend_rd_o) & (rs != 0).
- Upstream must hold valid_i and all data stable until accepted; the sequencer never drops an accepted result.
- Reset mid-sequence: the in-flight sequence is discarded and write_o falls asynchronously. A half-written register is acceptable because the regfile also resets.

Decomposition:
- Shared typedefs package:
  - wb_type_t enum (3-bit): WB_WORD=0, WB_LB=1, WB_LH=2, WB_LBU=3, WB_LHU=4.
  - wb_state_t enum: IDLE, WR_LO, WR_HI.
  - Constant HALF_W = 16.
- One combinational sub-module, wb_load_fmt: inputs result, wb_type, byte_off; output 32-bit formatted value. It is instantiated once, ahead of the hold register.

Test Plan:
- Reset, then accept WB_WORD, rd=5, result=0xDEADBEEF -> next cycle write_o=1, rd_o=5, h_sel=0, data=0xBEEF; following cycle h_sel=1, data=0xDEAD; then IDLE, pend_valid_o=0.
- WB_LB, byte_off=2, result=0x0080FF00 -> halves written 0xFF80 then 0xFFFF. The same stimulus with WB_LBU -> 0x0080 then 0x0000.
- WB_LH, byte_off=2, result=0x8001_1234 -> 0x8001 then 0xFFFF. WB_LHU -> 0x8001 then 0x0000.
- valid_i held high with rd=1,2,3 (distinct data) -> writes with h_sel pattern 0,1,0,1,0,1 on consecutive cycles with no bubble; ready_o toggles 1,0,1,0,...; pend_rd_o tracks 1,1,2,2,3,3.
- rd=0, SKIP_X0=1 -> accepted, write_o never asserts, ready_o stays 1. With SKIP_X0=0 -> two cycles with write_o=0, ready_o low in the middle cycle.
- Assert rst during WR_LO after accepting rd=7 -> write_o, pend_valid_o and all outputs drop to 0 immediately without waiting for a clock edge. After release: IDLE, ready_o=1, no stale write.
